// File: rtl/arp_defense_pkg.sv
// Shared definitions for the ARP-defense lookup path: opcodes, verdict
// reasons and the requester state encoding.
package arp_defense_pkg;

    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    typedef enum logic [1:0] {
        REASON_OK          = 2'd0,
        REASON_UNSOLICITED = 2'd1,
        REASON_TIMEOUT     = 2'd2,
        REASON_BAD_OPCODE  = 2'd3
    } reason_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        DECIDE    = 3'd3,
        VERDICT   = 3'd4
    } state_e;

    function automatic logic op_is_arp(input logic [15:0] op);
        return (op == ARP_OP_REQUEST) || (op == ARP_OP_REPLY);
    endfunction

endpackage

// File: rtl/arp_pending_table.sv
// Outstanding ARP request table: insert with first-free/round-robin victim,
// parallel match on valid entries, consume on reply, per-entry aging.
module arp_pending_table #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WINDOW = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ins_en,
    input  logic [47:0] ins_ip,
    input  logic [47:0] chk_ip,
    output logic        chk_hit,
    input  logic        cons_en
);
    localparam int unsigned AW = $clog2(WINDOW + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The insert cycle counts as the first aging cycle, so a reply checked
    // exactly WINDOW cycles after insert finds the entry already gone.
    localparam logic [AW-1:0] AGE_LOAD = AW'(WINDOW - 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [47:0]      ip_q  [DEPTH];
    logic [47:0]      ip_d  [DEPTH];
    logic [AW-1:0]    age_q [DEPTH];
    logic [AW-1:0]    age_d [DEPTH];
    logic [PW-1:0]    victim_q, victim_d;
    logic [DEPTH-1:0] match_s;
    logic [PW-1:0]    match_idx_s;
    logic [PW-1:0]    ins_idx_s;
    logic             free_found_s;

    // Parallel compare against valid entries only.
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = valid_q[i] && (ip_q[i] == chk_ip);
        end
    end

    assign chk_hit = |match_s;

    // Lowest matching index and lowest free index (descending scan, last write wins).
    always_comb begin
        match_idx_s  = {PW{1'b0}};
        ins_idx_s    = victim_q;
        free_found_s = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_s[i]) begin
                match_idx_s = i[PW-1:0];
            end else begin
                match_idx_s = match_idx_s;
            end
            if (!valid_q[i]) begin
                ins_idx_s    = i[PW-1:0];
                free_found_s = 1'b1;
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Next-state: aging first, then consume, then insert so insert has final priority.
    always_comb begin
        valid_d  = valid_q;
        victim_d = victim_q;
        for (int i = 0; i < DEPTH; i++) begin
            ip_d[i]  = ip_q[i];
            age_d[i] = age_q[i];
            if (valid_q[i]) begin
                if (age_q[i] <= AW'(1)) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = {AW{1'b0}};
                end else begin
                    age_d[i] = age_q[i] - AW'(1);
                end
            end else begin
                age_d[i] = {AW{1'b0}};
            end
        end
        if (cons_en && chk_hit) begin
            valid_d[match_idx_s] = 1'b0;
            age_d[match_idx_s]   = {AW{1'b0}};
        end else begin
            valid_d = valid_d;
        end
        if (ins_en) begin
            valid_d[ins_idx_s] = 1'b1;
            ip_d[ins_idx_s]    = ins_ip;
            age_d[ins_idx_s]   = AGE_LOAD;
            if (!free_found_s) begin
                victim_d = (victim_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : victim_q + 1'b1;
            end else begin
                victim_d = victim_q;
            end
        end else begin
            victim_d = victim_d;
        end
    end

    // Table state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= {DEPTH{1'b0}};
            victim_q <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ip_q[i]  <= 48'h0;
                age_q[i] <= {AW{1'b0}};
            end
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
            for (int i = 0; i < DEPTH; i++) begin
                ip_q[i]  <= ip_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/arp_lookup_requester.sv
// ARP-defense lookup initiator: one CAM lookup per parsed ARP header, then a
// forward/drop verdict based on the LUT result and outstanding requests.
module arp_lookup_requester
    import arp_defense_pkg::*;
#(
    parameter int unsigned                  NUM_OUTPUT_QUEUES         = 8,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55,
    parameter int unsigned                  LOOKUP_TIMEOUT            = 16,
    parameter int unsigned                  REPLY_WINDOW              = 100,
    parameter int unsigned                  PENDING_DEPTH             = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hdr_valid,
    output logic                         hdr_ready,
    input  logic [47:0]                  hdr_src_ip,
    input  logic [47:0]                  hdr_dst_ip,
    input  logic [15:0]                  hdr_opcode,
    input  logic [NUM_OUTPUT_QUEUES-1:0] hdr_src_port,
    output logic                         lookup_req,
    output logic [47:0]                  dst_IP,
    output logic [47:0]                  src_IP,
    output logic [15:0]                  opcode,
    input  logic                         lookup_done,
    input  logic                         lut_hit,
    input  logic                         lut_miss,
    output logic                         verdict_valid,
    input  logic                         verdict_ready,
    output logic                         verdict_drop,
    output logic [1:0]                   verdict_reason,
    output logic                         verdict_hit,
    output logic [NUM_OUTPUT_QUEUES-1:0] verdict_dst_ports
);
    localparam int unsigned   TW           = $clog2(LOOKUP_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(LOOKUP_TIMEOUT);
    localparam int unsigned   NQ           = NUM_OUTPUT_QUEUES;

    state_e            state_q, state_d;
    logic [47:0]       src_ip_q, src_ip_d;
    logic [47:0]       dst_ip_q, dst_ip_d;
    logic [15:0]       op_q, op_d;
    logic [NQ-1:0]     port_q, port_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              hit_q, hit_d;
    logic              hdr_ready_q, hdr_ready_d;
    logic              lookup_req_q, lookup_req_d;
    logic              v_valid_q, v_valid_d;
    logic              v_drop_q, v_drop_d;
    logic [1:0]        v_reason_q, v_reason_d;
    logic              v_hit_q, v_hit_d;
    logic [NQ-1:0]     v_ports_q, v_ports_d;
    logic              ins_en_s;
    logic              cons_en_s;
    logic              chk_hit_s;

    arp_pending_table #(
        .DEPTH  (PENDING_DEPTH),
        .WINDOW (REPLY_WINDOW)
    ) u_pending (
        .clk     (clk),
        .reset   (reset),
        .ins_en  (ins_en_s),
        .ins_ip  (dst_ip_q),
        .chk_ip  (src_ip_q),
        .chk_hit (chk_hit_s),
        .cons_en (cons_en_s)
    );

    // Next-state and verdict computation.
    always_comb begin
        state_d    = state_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        op_d       = op_q;
        port_d     = port_q;
        timer_d    = timer_q;
        hit_d      = hit_q;
        v_drop_d   = v_drop_q;
        v_reason_d = v_reason_q;
        v_hit_d    = v_hit_q;
        v_ports_d  = v_ports_q;
        ins_en_s   = 1'b0;
        cons_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_valid && hdr_ready_q) begin
                    src_ip_d = hdr_src_ip;
                    dst_ip_d = hdr_dst_ip;
                    op_d     = hdr_opcode;
                    port_d   = hdr_src_port;
                    hit_d    = 1'b0;
                    if (op_is_arp(hdr_opcode)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d    = VERDICT;
                        v_drop_d   = 1'b1;
                        v_reason_d = REASON_BAD_OPCODE;
                        v_hit_d    = 1'b0;
                        v_ports_d  = {NQ{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                timer_d = TIMEOUT_LOAD;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_d = timer_q - TW'(1);
                if (lookup_done) begin
                    // A reply flagging both hit and miss is treated as no hit.
                    hit_d   = lut_hit & ~lut_miss;
                    state_d = DECIDE;
                end else if (timer_q <= TW'(1)) begin
                    timer_d    = {TW{1'b0}};
                    state_d    = VERDICT;
                    v_drop_d   = 1'b1;
                    v_reason_d = REASON_TIMEOUT;
                    v_hit_d    = 1'b0;
                    v_ports_d  = {NQ{1'b0}};
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            DECIDE: begin
                state_d = VERDICT;
                v_hit_d = hit_q;
                if (op_q == ARP_OP_REQUEST) begin
                    ins_en_s   = 1'b1;
                    v_drop_d   = 1'b0;
                    v_reason_d = REASON_OK;
                    v_ports_d  = DEFAULT_MISS_OUTPUT_PORTS & ~port_q;
                end else if (chk_hit_s) begin
                    cons_en_s  = 1'b1;
                    v_drop_d   = 1'b0;
                    v_reason_d = REASON_OK;
                    v_ports_d  = DEFAULT_MISS_OUTPUT_PORTS & ~port_q;
                end else begin
                    v_drop_d   = 1'b1;
                    v_reason_d = REASON_UNSOLICITED;
                    v_ports_d  = {NQ{1'b0}};
                end
            end
            VERDICT: begin
                if (verdict_ready) begin
                    state_d    = IDLE;
                    v_drop_d   = 1'b0;
                    v_reason_d = REASON_OK;
                    v_hit_d    = 1'b0;
                    v_ports_d  = {NQ{1'b0}};
                end else begin
                    state_d = VERDICT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hdr_ready_d  = (state_d == IDLE);
        lookup_req_d = (state_d == ISSUE);
        v_valid_d    = (state_d == VERDICT);
    end

    // State, latched header and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_ip_q     <= 48'h0;
            dst_ip_q     <= 48'h0;
            op_q         <= 16'h0;
            port_q       <= {NQ{1'b0}};
            timer_q      <= {TW{1'b0}};
            hit_q        <= 1'b0;
            hdr_ready_q  <= 1'b0;
            lookup_req_q <= 1'b0;
            v_valid_q    <= 1'b0;
            v_drop_q     <= 1'b0;
            v_reason_q   <= 2'd0;
            v_hit_q      <= 1'b0;
            v_ports_q    <= {NQ{1'b0}};
        end else begin
            state_q      <= state_d;
            src_ip_q     <= src_ip_d;
            dst_ip_q     <= dst_ip_d;
            op_q         <= op_d;
            port_q       <= port_d;
            timer_q      <= timer_d;
            hit_q        <= hit_d;
            hdr_ready_q  <= hdr_ready_d;
            lookup_req_q <= lookup_req_d;
            v_valid_q    <= v_valid_d;
            v_drop_q     <= v_drop_d;
            v_reason_q   <= v_reason_d;
            v_hit_q      <= v_hit_d;
            v_ports_q    <= v_ports_d;
        end
    end

    assign hdr_ready         = hdr_ready_q;
    assign lookup_req        = lookup_req_q;
    assign dst_IP            = dst_ip_q;
    assign src_IP            = src_ip_q;
    assign opcode            = op_q;
    assign verdict_valid     = v_valid_q;
    assign verdict_drop      = v_drop_q;
    assign verdict_reason    = v_reason_q;
    assign verdict_hit       = v_hit_q;
    assign verdict_dst_ports = v_ports_q;

endmodule

// File: tb/tb_arp_lookup_requester.sv
// Directed bench for arp_lookup_requester; the bench plays the LUT and the
// downstream verdict consumer.
module tb_arp_lookup_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr_src_ip;
    logic [47:0] hdr_dst_ip;
    logic [15:0] hdr_opcode;
    logic [7:0]  hdr_src_port;
    logic        lookup_req;
    logic [47:0] dst_IP;
    logic [47:0] src_IP;
    logic [15:0] opcode;
    logic        lookup_done;
    logic        lut_hit;
    logic        lut_miss;
    logic        verdict_valid;
    logic        verdict_ready;
    logic        verdict_drop;
    logic [1:0]  verdict_reason;
    logic        verdict_hit;
    logic [7:0]  verdict_dst_ports;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int req_count   = 0;
    int acc_cyc     = 0;

    localparam logic [47:0] IP_A = 48'h0000_0A00_0001;
    localparam logic [47:0] IP_B = 48'h0000_0A00_0002;
    localparam logic [47:0] IP_C = 48'h0000_0A00_0003;
    localparam logic [47:0] IP_D = 48'h0000_0A00_0004;
    localparam logic [47:0] IP_9 = 48'h0000_0A00_0009;

    arp_lookup_requester dut (
        .clk               (clk),
        .reset             (reset),
        .hdr_valid         (hdr_valid),
        .hdr_ready         (hdr_ready),
        .hdr_src_ip        (hdr_src_ip),
        .hdr_dst_ip        (hdr_dst_ip),
        .hdr_opcode        (hdr_opcode),
        .hdr_src_port      (hdr_src_port),
        .lookup_req        (lookup_req),
        .dst_IP            (dst_IP),
        .src_IP            (src_IP),
        .opcode            (opcode),
        .lookup_done       (lookup_done),
        .lut_hit           (lut_hit),
        .lut_miss          (lut_miss),
        .verdict_valid     (verdict_valid),
        .verdict_ready     (verdict_ready),
        .verdict_drop      (verdict_drop),
        .verdict_reason    (verdict_reason),
        .verdict_hit       (verdict_hit),
        .verdict_dst_ports (verdict_dst_ports)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lookup_req === 1'b1) req_count <= req_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_hdr(input logic [47:0] s, input logic [47:0] d,
                            input logic [15:0] op, input logic [7:0] port);
        int n = 0;
        while (hdr_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("hdr_ready_before_send", {63'd0, hdr_ready}, 64'd1);
        hdr_valid    = 1'b1;
        hdr_src_ip   = s;
        hdr_dst_ip   = d;
        hdr_opcode   = op;
        hdr_src_port = port;
        acc_cyc      = cyc;
        tick();
        hdr_valid = 1'b0;
    endtask

    task automatic send_at(input int target, input logic [47:0] s, input logic [47:0] d,
                           input logic [15:0] op, input logic [7:0] port);
        int n = 0;
        while (cyc < target && n < 300) begin
            tick();
            n++;
        end
        check("send_at_cycle", 64'(cyc), 64'(target));
        send_hdr(s, d, op, port);
    endtask

    // LUT model: answers two cycles after the request pulse.
    task automatic lut_serve(input logic hit, input logic [47:0] exp_dst,
                             input logic [47:0] exp_src, input logic [15:0] exp_op);
        int n = 0;
        while (lookup_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("lookup_req_seen", {63'd0, lookup_req}, 64'd1);
        check("lookup_dst_IP", {16'd0, dst_IP}, {16'd0, exp_dst});
        check("lookup_src_IP", {16'd0, src_IP}, {16'd0, exp_src});
        check("lookup_opcode", {48'd0, opcode}, {48'd0, exp_op});
        tick();
        check("lookup_req_single", {63'd0, lookup_req}, 64'd0);
        tick();
        lookup_done = 1'b1;
        lut_hit     = hit;
        lut_miss    = ~hit;
        tick();
        lookup_done = 1'b0;
        lut_hit     = 1'b0;
        lut_miss    = 1'b0;
    endtask

    task automatic take_verdict(input string tag, input logic drop, input logic [1:0] reason,
                                input logic hit, input logic [7:0] ports, input int lat,
                                input int stall);
        int n = 0;
        while (verdict_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, verdict_valid}, 64'd1);
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
        for (int i = 0; i <= stall; i++) begin
            check({tag, "_drop"}, {63'd0, verdict_drop}, {63'd0, drop});
            check({tag, "_reason"}, {62'd0, verdict_reason}, {62'd0, reason});
            check({tag, "_hit"}, {63'd0, verdict_hit}, {63'd0, hit});
            check({tag, "_ports"}, {56'd0, verdict_dst_ports}, {56'd0, ports});
            check({tag, "_hdr_ready_low"}, {63'd0, hdr_ready}, 64'd0);
            if (i < stall) begin
                tick();
                check({tag, "_valid_held"}, {63'd0, verdict_valid}, 64'd1);
            end else begin
                verdict_ready = 1'b1;
            end
        end
        tick();
        verdict_ready = 1'b0;
        check({tag, "_valid_cleared"}, {63'd0, verdict_valid}, 64'd0);
        check({tag, "_back_idle"}, {63'd0, hdr_ready}, 64'd1);
    endtask

    initial begin
        int q;
        int r0;
        reset         = 1'b1;
        hdr_valid     = 1'b0;
        hdr_src_ip    = 48'h0;
        hdr_dst_ip    = 48'h0;
        hdr_opcode    = 16'h0;
        hdr_src_port  = 8'h00;
        lookup_done   = 1'b0;
        lut_hit       = 1'b0;
        lut_miss      = 1'b0;
        verdict_ready = 1'b0;
        tick();
        tick();
        tick();
        check("rst_hdr_ready", {63'd0, hdr_ready}, 64'd0);
        check("rst_lookup_req", {63'd0, lookup_req}, 64'd0);
        check("rst_verdict_valid", {63'd0, verdict_valid}, 64'd0);
        check("rst_dst_ports", {56'd0, verdict_dst_ports}, 64'd0);
        check("rst_dst_IP", {16'd0, dst_IP}, 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_no_req", {63'd0, lookup_req}, 64'd0);
        check("post_rst_ready", {63'd0, hdr_ready}, 64'd1);

        // Request then solicited reply 20 cycles later; repeat reply is unsolicited.
        send_hdr(IP_A, IP_B, 16'h0001, 8'h01);
        q = acc_cyc;
        lut_serve(1'b1, IP_B, IP_A, 16'h0001);
        take_verdict("t1_req", 1'b0, 2'd0, 1'b1, 8'h54, 5, 0);
        send_at(q + 20, IP_B, IP_A, 16'h0002, 8'h01);
        lut_serve(1'b0, IP_A, IP_B, 16'h0002);
        take_verdict("t1_rep", 1'b0, 2'd0, 1'b0, 8'h54, 5, 0);
        send_hdr(IP_B, IP_A, 16'h0002, 8'h01);
        lut_serve(1'b0, IP_A, IP_B, 16'h0002);
        take_verdict("t1_rep2", 1'b1, 2'd1, 1'b0, 8'h00, 5, 0);

        // Unsolicited reply.
        send_hdr(IP_9, IP_A, 16'h0002, 8'h04);
        lut_serve(1'b1, IP_A, IP_9, 16'h0002);
        take_verdict("t2_unsol", 1'b1, 2'd1, 1'b1, 8'h00, 5, 0);

        // Reply window boundary: 100 cycles expired, 99 cycles still live.
        send_hdr(IP_C, IP_D, 16'h0001, 8'h02);
        q = acc_cyc;
        lut_serve(1'b0, IP_D, IP_C, 16'h0001);
        take_verdict("t3_req100", 1'b0, 2'd0, 1'b0, 8'h55, 5, 0);
        send_at(q + 100, IP_D, IP_C, 16'h0002, 8'h10);
        lut_serve(1'b0, IP_C, IP_D, 16'h0002);
        take_verdict("t3_rep100", 1'b1, 2'd1, 1'b0, 8'h00, 5, 0);
        send_hdr(IP_C, IP_D, 16'h0001, 8'h02);
        q = acc_cyc;
        lut_serve(1'b0, IP_D, IP_C, 16'h0001);
        take_verdict("t3_req99", 1'b0, 2'd0, 1'b0, 8'h55, 5, 0);
        send_at(q + 99, IP_D, IP_C, 16'h0002, 8'h10);
        lut_serve(1'b0, IP_C, IP_D, 16'h0002);
        take_verdict("t3_rep99", 1'b0, 2'd0, 1'b0, 8'h45, 5, 0);

        // LUT silent: single request pulse, timeout verdict, late done ignored.
        r0 = req_count;
        send_hdr(IP_A, IP_B, 16'h0001, 8'h01);
        take_verdict("t4_timeout", 1'b1, 2'd2, 1'b0, 8'h00, 18, 0);
        check("t4_req_pulses", 64'(req_count - r0), 64'd1);
        lookup_done = 1'b1;
        lut_hit     = 1'b1;
        tick();
        lookup_done = 1'b0;
        lut_hit     = 1'b0;
        tick();
        check("t4_late_no_verdict", {63'd0, verdict_valid}, 64'd0);
        check("t4_late_idle", {63'd0, hdr_ready}, 64'd1);
        check("t4_late_no_req", 64'(req_count - r0), 64'd1);

        // Bad opcode: no lookup, one-cycle verdict.
        r0 = req_count;
        send_hdr(IP_A, IP_B, 16'h0003, 8'h01);
        take_verdict("t5_badop", 1'b1, 2'd3, 1'b0, 8'h00, 1, 0);
        check("t5_no_req", 64'(req_count - r0), 64'd0);

        // Reset in the middle of a lookup.
        send_hdr(IP_A, IP_B, 16'h0001, 8'h01);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_rst_valid", {63'd0, verdict_valid}, 64'd0);
        check("t6_rst_ready", {63'd0, hdr_ready}, 64'd0);
        check("t6_rst_req", {63'd0, lookup_req}, 64'd0);
        reset = 1'b0;
        r0 = req_count;
        tick();
        check("t6_post_rst_no_req", {63'd0, lookup_req}, 64'd0);
        check("t6_post_rst_ready", {63'd0, hdr_ready}, 64'd1);

        // Five requests overflow four entries; the first target is evicted.
        for (int k = 1; k <= 5; k++) begin
            send_hdr(IP_A, 48'h0000_0A00_0010 + 48'(k), 16'h0001, 8'h01);
            lut_serve(1'b1, 48'h0000_0A00_0010 + 48'(k), IP_A, 16'h0001);
            take_verdict("t7_fill", 1'b0, 2'd0, 1'b1, 8'h54, 5, 0);
        end
        check("t7_req_count", 64'(req_count - r0), 64'd5);
        send_hdr(48'h0000_0A00_0011, IP_A, 16'h0002, 8'h01);
        lut_serve(1'b0, IP_A, 48'h0000_0A00_0011, 16'h0002);
        take_verdict("t7_evicted", 1'b1, 2'd1, 1'b0, 8'h00, 5, 0);
        send_hdr(48'h0000_0A00_0015, IP_A, 16'h0002, 8'h01);
        lut_serve(1'b1, IP_A, 48'h0000_0A00_0015, 16'h0002);
        take_verdict("t7_fifth_stall", 1'b0, 2'd0, 1'b1, 8'h54, 5, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
